poxi_axil_regfile: RTL and testbench

- AXI4-Lite slave register file for the POXI IP. It sits directly downstream of the S00_AXI AXI4-Lite master (system BFM or PS interconnect).
- Provides NUM_REGS 32-bit read/write control registers at byte offsets 0x0, 0x4, 0x8, ...
- Exposes the register contents and per-register write pulses to POXI fabric logic.
- Unmapped addresses return SLVERR.

---
 rtl/poxi_axil_regfile.sv | 153 +++++++++++++++
 tb/tb_poxi_axil_regfile.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/poxi_axil_regfile.sv
// poxi_axil_regfile: AXI4-Lite slave register file with per-register write pulses
module poxi_axil_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS = 4
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0]                    reg_wr_pulse
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int IW = AW - 2;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  w_state_t w_state;
  r_state_t r_state;
  logic [DW-1:0] regs [NUM_REGS];
  logic [AW-1:0] addr_q, wr_addr;
  logic [DW-1:0] data_q, wr_data, rd_val;
  logic [SW-1:0] strb_q, wr_strb;
  logic [IW-1:0] wr_idx, rd_idx;
  logic aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok;
  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};
  // The half of the pair that arrived first is replayed from its holding register.
  always_comb begin
    aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    w_hs = S_AXI_WVALID && S_AXI_WREADY;
    ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    commit = (w_state == W_IDLE && aw_hs && w_hs) || (w_state == W_ADDR && w_hs) ||
             (w_state == W_DATA && aw_hs);
    wr_addr = w_state == W_ADDR ? addr_q : S_AXI_AWADDR;
    wr_data = w_state == W_DATA ? data_q : S_AXI_WDATA;
    wr_strb = w_state == W_DATA ? strb_q : S_AXI_WSTRB;
    wr_idx = wr_addr[AW-1:2];
    rd_idx = S_AXI_ARADDR[AW-1:2];
    wr_ok = int'(wr_idx) < NUM_REGS;
    rd_ok = int'(rd_idx) < NUM_REGS;
    rd_val = '0;
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IW'(i)) rd_val = regs[i];
      reg_out[DW*i +: DW] = regs[i];
    end
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      w_state <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP <= 2'b00;
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            w_state <= W_RESP;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY <= 1'b0;
          end else if (aw_hs) begin
            w_state <= W_ADDR;
            addr_q <= S_AXI_AWADDR;
            S_AXI_AWREADY <= 1'b0;
          end else if (w_hs) begin
            w_state <= W_DATA;
            data_q <= S_AXI_WDATA;
            strb_q <= S_AXI_WSTRB;
            S_AXI_WREADY <= 1'b0;
          end else begin
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY <= 1'b1;
          end
        end
        W_ADDR: if (w_hs) begin
          w_state <= W_RESP;
          S_AXI_WREADY <= 1'b0;
        end
        W_DATA: if (aw_hs) begin
          w_state <= W_RESP;
          S_AXI_AWREADY <= 1'b0;
        end
        default: if (S_AXI_BREADY) begin
          w_state <= W_IDLE;
          S_AXI_BVALID <= 1'b0;
          S_AXI_AWREADY <= 1'b1;
          S_AXI_WREADY <= 1'b1;
        end
      endcase
      if (commit) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP <= wr_ok ? 2'b00 : 2'b10;
      end
    end
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_wr_pulse[i] <= commit && wr_ok && wr_idx == IW'(i);
        for (int b = 0; b < SW; b++)
          if (commit && wr_ok && wr_idx == IW'(i) && wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      r_state <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= 2'b00;
    end else if (r_state == R_IDLE) begin
      S_AXI_ARREADY <= !ar_hs;
      if (ar_hs) begin
        r_state <= R_RESP;
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA <= rd_val;
        S_AXI_RRESP <= rd_ok ? 2'b00 : 2'b10;
      end
    end else if (S_AXI_RREADY) begin
      r_state <= R_IDLE;
      S_AXI_RVALID <= 1'b0;
      S_AXI_ARREADY <= 1'b1;
    end
  end
endmodule

// File: tb/tb_poxi_axil_regfile.sv
// tb_poxi_axil_regfile: scoreboard bench for poxi_axil_regfile with directed vectors
module tb_poxi_axil_regfile;
  logic clk = 0;
  logic aresetn = 0;
  logic [4:0] awaddr = 0, araddr = 0;
  logic [2:0] awprot = 0, arprot = 0;
  logic awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic [31:0] wdata = 0;
  logic [3:0] wstrb = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [127:0] reg_out;
  logic [3:0] reg_wr_pulse;
  int n_vec = 0, n_err = 0;
  bit bprev = 0;
  typedef struct {logic [1:0] resp; logic [3:0] pulse;} b_t;
  typedef struct {logic [31:0] data; logic [1:0] resp;} r_t;
  b_t q_b[$];
  r_t q_r[$];

  poxi_axil_regfile dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pulses are checked when BVALID rises, responses when the handshake is visible.
  initial forever begin
    b_t eb;
    r_t er;
    @(negedge clk);
    if (bvalid && !bprev) begin
      if (q_b.size() == 0) chk("b_unexpected", 1, 0);
      else chk("wr_pulse", reg_wr_pulse, q_b[0].pulse);
    end else if (reg_wr_pulse != 0) chk("stray_pulse", reg_wr_pulse, 0);
    if (bvalid && bready) begin
      if (q_b.size() == 0) chk("b_unexpected", 1, 0);
      else begin
        eb = q_b.pop_front();
        chk("bresp", bresp, eb.resp);
      end
    end
    if (rvalid && rready) begin
      if (q_r.size() == 0) chk("r_unexpected", 1, 0);
      else begin
        er = q_r.pop_front();
        chk("rresp", rresp, er.resp);
        chk("rdata", rdata, er.data);
      end
    end
    bprev = bvalid;
  end

  task automatic send_aw(input logic [4:0] a);
    int t = 0;
    awaddr = a;
    awvalid = 1;
    do begin @(negedge clk); t++; end while (!awready && t < 50);
    if (!awready) chk("aw_timeout", 0, 1);
    @(posedge clk); #1 awvalid = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int t = 0;
    wdata = d;
    wstrb = s;
    wvalid = 1;
    do begin @(negedge clk); t++; end while (!wready && t < 50);
    if (!wready) chk("w_timeout", 0, 1);
    @(posedge clk); #1 wvalid = 0;
  endtask

  task automatic send_ar(input logic [4:0] a);
    int t = 0;
    araddr = a;
    arvalid = 1;
    do begin @(negedge clk); t++; end while (!arready && t < 50);
    if (!arready) chk("ar_timeout", 0, 1);
    @(posedge clk); #1 arvalid = 0;
  endtask

  task automatic wait_b();
    int t = 0;
    while (q_b.size() != 0 && t < 50) begin @(posedge clk); t++; end
    if (q_b.size() != 0) chk("b_timeout", 0, 1);
    #1;
  endtask

  task automatic wait_r();
    int t = 0;
    while (q_r.size() != 0 && t < 50) begin @(posedge clk); t++; end
    if (q_r.size() != 0) chk("r_timeout", 0, 1);
    #1;
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] r, input logic [3:0] p, input int lead, input bit done);
    logic [127:0] pre = reg_out;
    q_b.push_back('{r, p});
    fork
      begin
        if (lead < 0) begin
          repeat (-lead) @(posedge clk);
          #1 chk("early_bvalid", bvalid, 0);
          chk("early_reg", reg_out, pre);
        end
        send_w(d, s);
      end
      begin
        if (lead > 0) begin
          repeat (lead) @(posedge clk);
          #1 chk("early_bvalid", bvalid, 0);
          chk("early_reg", reg_out, pre);
        end
        send_aw(a);
      end
    join
    chk("bvalid_lat", bvalid, 1);
    if (done) wait_b();
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] d, input logic [1:0] r);
    q_r.push_back('{d, r});
    send_ar(a);
    chk("rvalid_lat", rvalid, 1);
    wait_r();
  endtask

  initial begin
    #200000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_reg_out", reg_out, 0);
    aresetn = 1;
    @(posedge clk); #1;
    chk("ready_up", {awready, wready, arready}, 3'b111);

    wr(5'h00, 32'h0101FFFF, 4'hF, 2'b00, 4'b0001, 0, 1);
    rd(5'h00, 32'h0101FFFF, 2'b00);
    wr(5'h04, 32'hABCD0001, 4'hF, 2'b00, 4'b0010, 0, 1);
    rd(5'h04, 32'hABCD0001, 2'b00);
    wr(5'h08, 32'hDEAD0011, 4'hF, 2'b00, 4'b0100, 0, 1);
    rd(5'h08, 32'hDEAD0011, 2'b00);
    wr(5'h0C, 32'hBEEF0011, 4'hF, 2'b00, 4'b1000, 0, 1);
    rd(5'h0C, 32'hBEEF0011, 2'b00);
    chk("reg_out_all", reg_out, 128'hBEEF0011_DEAD0011_ABCD0001_0101FFFF);

    wr(5'h04, 32'h12345678, 4'hF, 2'b00, 4'b0010, 3, 1);
    rd(5'h04, 32'h12345678, 2'b00);
    wr(5'h04, 32'hCAFEF00D, 4'hF, 2'b00, 4'b0010, -3, 1);
    rd(5'h04, 32'hCAFEF00D, 2'b00);

    wr(5'h00, 32'hFFFFFFFF, 4'hF, 2'b00, 4'b0001, 0, 1);
    wr(5'h00, 32'h00000000, 4'b0101, 2'b00, 4'b0001, 0, 1);
    rd(5'h00, 32'hFF00FF00, 2'b00);

    wr(5'h10, 32'h5555AAAA, 4'hF, 2'b10, 4'b0000, 0, 1);
    chk("err_reg_out", reg_out, 128'hBEEF0011_DEAD0011_CAFEF00D_FF00FF00);
    rd(5'h14, 32'h0, 2'b10);

    bready = 0;
    wr(5'h0C, 32'hBEEF0011, 4'hF, 2'b00, 4'b1000, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bstall_valid", bvalid, 1);
      chk("bstall_resp", bresp, 2'b00);
      chk("bstall_ready", {awready, wready}, 2'b00);
    end
    @(posedge clk); #1 bready = 1;
    wait_b();

    rready = 0;
    q_r.push_back('{32'hBEEF0011, 2'b00});
    send_ar(5'h0C);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rstall_valid", rvalid, 1);
      chk("rstall_data", rdata, 32'hBEEF0011);
      chk("rstall_ready", arready, 0);
    end
    @(posedge clk); #1 rready = 1;
    wait_r();

    q_b.push_back('{2'b00, 4'b0100});
    q_r.push_back('{32'hDEAD0011, 2'b00});
    fork
      send_aw(5'h08);
      send_w(32'h0, 4'hF);
      send_ar(5'h08);
    join
    wait_b();
    wait_r();
    rd(5'h08, 32'h0, 2'b00);

    bready = 0;
    wr(5'h04, 32'h77777777, 4'hF, 2'b00, 4'b0010, 0, 0);
    aresetn = 0;
    @(posedge clk); #1;
    chk("rst_mid_bvalid", bvalid, 0);
    chk("rst_mid_reg_out", reg_out, 0);
    aresetn = 1;
    q_b.delete();
    bready = 1;
    @(posedge clk); #1;
    rd(5'h04, 32'h0, 2'b00);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
